// File: rtl/pwm_frame_encoder.sv
// Serial bit capture (scl/sda, synchronized) into a circular FIFO, then framed
// PWM transmission: START low, per-bit MARK high (T1/T0) + SPACE low, STOP high.
module pwm_frame_encoder #(
  parameter int DEPTH        = 16,
  parameter int FRAME_BITS   = 8,
  parameter int T1           = 20,
  parameter int T0           = 10,
  parameter int GAP          = 5,
  parameter int START_CYCLES = 5,
  parameter int STOP_CYCLES  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  input  logic                     sda,
  input  logic                     wen,
  input  logic                     op_en,
  input  logic                     clr_err,
  output logic                     sg_out,
  output logic [$clog2(DEPTH):0]   buff_count,
  output logic                     buff_full,
  output logic                     buff_empty,
  output logic                     overflow_err,
  output logic                     busy,
  output logic                     frame_done,
  output logic [2:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_MARK  = 3'd2,
    S_SPACE = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_scl_prev;
  logic          r_sda_s1, r_sda_s2;
  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  state_t        r_state;
  logic [31:0]   r_cnt;
  logic [CW-1:0] r_bits;
  logic          r_sg, r_busy, r_done;

  logic          w_edge, w_push, w_pop, w_full, w_accept, w_drop, w_head;
  logic [31:0]   w_mark_len;

  assign w_edge     = r_scl_s2 & ~r_scl_prev;
  assign w_push     = w_edge & wen;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = (r_state == S_SPACE) && (r_cnt == 32'(GAP - 1));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_accept   = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_mark_len = w_head ? 32'(T1) : 32'(T0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1   <= 1'b0;
      r_scl_s2   <= 1'b0;
      r_scl_prev <= 1'b0;
      r_sda_s1   <= 1'b0;
      r_sda_s2   <= 1'b0;
    end else begin
      r_scl_s1   <= scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= sda;
      r_sda_s2   <= r_sda_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_sda_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A fresh overflow takes priority over a simultaneous clear.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_sg    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sg <= 1'b1;
          if (op_en && (r_count >= CW'(FRAME_BITS))) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_sg    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == 32'(START_CYCLES - 1)) begin
            r_state <= S_MARK;
            r_cnt   <= '0;
            r_sg    <= 1'b1;
          end else r_cnt <= r_cnt + 32'd1;
        end
        S_MARK: begin
          if (r_cnt == w_mark_len - 32'd1) begin
            r_state <= S_SPACE;
            r_cnt   <= '0;
            r_sg    <= 1'b0;
          end else r_cnt <= r_cnt + 32'd1;
        end
        S_SPACE: begin
          if (r_cnt == 32'(GAP - 1)) begin
            r_cnt  <= '0;
            r_bits <= r_bits + CW'(1);
            r_sg   <= 1'b1;
            if (r_bits == CW'(FRAME_BITS - 1)) r_state <= S_STOP;
            else                               r_state <= S_MARK;
          end else r_cnt <= r_cnt + 32'd1;
        end
        S_STOP: begin
          if (r_cnt == 32'(STOP_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else r_cnt <= r_cnt + 32'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sg    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sg_out       = r_sg;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  assign buff_count   = r_count;
  assign buff_full    = w_full;
  assign buff_empty   = (r_count == '0);
  assign overflow_err = r_ovf;
  assign dbg_state    = r_state;

endmodule
